audio_rate_sink: RTL and testbench
==================================

// Module: audio_rate_sink
// PURPOSE
//  Consumer end of an audiostream: pulls samples from an upstream audiostream source (FIFO) at a
//  programmable sample rate set by a phase-accumulator NCO. Presents them as held stereo words to
//  the mixer/DAC stage. Supports interleaved stereo (L then R) and mono (duplicated) streams.
//  Detects and counts underruns (sample period elapsed before a full frame was fetched).
// PARAMETERS
//  ACC_W   24  phase accumulator width; tick rate = clk_freq * rate_inc / 2**ACC_W
// PORTS
//  clk           in   1      system clock
//  reset         in   1      synchronous, active-high reset
//  in            sink audiostream  upstream source; sample/write driven by source, strobe driven here
//  enable        in   1      1 = NCO runs and frames are fetched
//  stereo        in   1      1 = stream is interleaved L,R; 0 = mono, sample copied to both channels
//  rate_inc      in   ACC_W  NCO phase increment per clk
//  left_out      out  16     signed left sample, held between frames
//  right_out     out  16     signed right sample, held between frames
//  sample_tick   out  1      1-cycle pulse, high in the first cycle new left/right_out are visible
//  underrun      out  1      1-cycle pulse per missed frame period
//  underrun_cnt  out  16     saturating count of underrun pulses
// BEHAVIOUR
//  Reset: acc=0, FSM=IDLE, left_out=right_out=0, sample_tick=underrun=0, underrun_cnt=0, in.strobe=0.
//  NCO: {carry,acc} = acc + rate_inc each clk while enable; carry = frame tick. enable=0: acc<=0, no ticks.
//  Handshake: transfer when in.write && in.strobe. in.strobe = (FSM in FETCH_L/FETCH_R) && in.write && !reset.
//  FSM (registered state):
//   IDLE    -> FETCH_L on tick.
//   FETCH_L  on transfer: latch pend_l; stereo ? FETCH_R : (pend_r = same sample, PRESENT).
//   FETCH_R  on transfer: latch pend_r; -> PRESENT.
//   PRESENT  left_out<=pend_l, right_out<=pend_r, sample_tick<=1; -> tick ? FETCH_L : IDLE.
//  Latency, stereo, source always valid: tick in cycle N -> L transfer N+1, R transfer N+2,
//   PRESENT N+3, new outputs + sample_tick in N+4. Mono: one cycle less.
//  Underrun: tick while in FETCH_L/FETCH_R -> underrun pulse next cycle, underrun_cnt+1 (saturates at
//   0xFFFF). FSM stays in its state; no channel swap; outputs hold last frame. Multiple missed ticks count once each.
//  stereo sampled on the FETCH_L transfer; changes mid-frame do not affect the current frame.
//  enable falling mid-frame: the current frame completes normally; no further ticks.
//  rate_inc must give >= 4 clk per tick. Faster rates are not supported and count as underruns.
//  Reset mid-frame: immediate return to reset values; partially fetched frame discarded.
//  Source with gaps (write low some cycles) is fine; only tick deadline matters.
// STRUCTURE
//  audio_pkg: typedef bit signed [15:0] sample_t; FSM enum (IDLE, FETCH_L, FETCH_R, PRESENT);
//   rate constants for 44.1/37.8/18.9 kHz at system clock (RATE_INC_44K1 etc.).
//  Sub-module audio_rate_nco: accumulator + enable/clear, outputs 1-cycle tick. FSM/regs in top.
// TESTING
//  1 reset held 3 clk mid-run -> left/right_out=0, strobe=0, underrun_cnt=0; next frame starts with L.
//  2 stereo, rate_inc=2**21, source always valid 0x1111,0x2222,0x3333,0x4444 -> sample_tick every 8 clk;
//    frame1 L=0x1111 R=0x2222, frame2 L=0x3333 R=0x4444, tick->outputs latency 4 clk.
//  3 mono, samples 0x8000,0x7FFF -> L=R=0x8000 then L=R=0x7FFF, one transfer per tick.
//  4 stereo, source write low for 20 clk after L transfer, rate 8 clk -> 2 underrun pulses, cnt=2,
//    outputs held; on resume next sample lands in right_out (alignment kept).
//  5 source valid every 3rd cycle, rate 16 clk -> no underrun, every frame correct, strobe only with write.
//  6 force underrun_cnt near 0xFFFF (long starvation) -> saturates at 0xFFFF; enable=0 mid-frame -> frame completes, no new ticks.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared types and constants for the audiostream sink: sample type, fetch FSM states,
// and NCO phase increments for the standard audio rates at the system clock.
package audio_pkg;

  typedef bit signed [15:0] sample_t;

  typedef enum logic [1:0] {
    IDLE,
    FETCH_L,
    FETCH_R,
    PRESENT
  } sink_state_t;

  localparam int              NCO_ACC_W    = 24;
  localparam longint unsigned SYS_CLK_HZ   = 64'd100_000_000;
  localparam logic [15:0]     UNDERRUN_MAX = 16'hFFFF;

  // Rounded increment so that SYS_CLK_HZ * inc / 2**NCO_ACC_W is closest to fs_hz.
  function automatic logic [NCO_ACC_W-1:0] rate_inc_for(input longint unsigned fs_hz);
    longint unsigned inc;
    inc = (fs_hz * (64'd1 << NCO_ACC_W) + SYS_CLK_HZ / 2) / SYS_CLK_HZ;
    return inc[NCO_ACC_W-1:0];
  endfunction

  localparam logic [NCO_ACC_W-1:0] RATE_INC_44K1 = rate_inc_for(64'd44_100);
  localparam logic [NCO_ACC_W-1:0] RATE_INC_37K8 = rate_inc_for(64'd37_800);
  localparam logic [NCO_ACC_W-1:0] RATE_INC_18K9 = rate_inc_for(64'd18_900);

endpackage

// File: rtl/audiostream_if.sv
// Audiostream link: the source drives sample/write, the consumer answers with strobe.
// A word moves in every cycle where write and strobe are both high.
interface audiostream_if;
  import audio_pkg::*;

  sample_t sample;
  logic    write;
  logic    strobe;

  modport source (output sample, output write, input strobe);
  modport sink   (input sample, input write, output strobe);

endinterface

// File: rtl/audio_rate_nco.sv
// Phase-accumulator NCO: adds rate_inc every clk while enabled and emits a registered
// 1-cycle tick on each accumulator carry. Disabling clears the phase.
module audio_rate_nco
  import audio_pkg::*;
#(
  parameter int ACC_W = NCO_ACC_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [ACC_W-1:0] rate_inc,
  output logic             tick
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   sum;

  assign sum = {1'b0, acc} + {1'b0, rate_inc};

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      acc  <= '0;
      tick <= 1'b0;
    end else begin
      acc  <= sum[ACC_W-1:0];
      tick <= sum[ACC_W];
    end
  end

endmodule

// File: rtl/audio_rate_sink.sv
// Audiostream consumer: on each NCO tick fetches one frame (L,R or a duplicated mono word),
// then presents it as held stereo outputs. Ticks that arrive mid-fetch are counted as underruns.
module audio_rate_sink
  import audio_pkg::*;
#(
  parameter int ACC_W = NCO_ACC_W
) (
  input  logic             clk,
  input  logic             reset,
  audiostream_if.sink      in,
  input  logic             enable,
  input  logic             stereo,
  input  logic [ACC_W-1:0] rate_inc,
  output sample_t          left_out,
  output sample_t          right_out,
  output logic             sample_tick,
  output logic             underrun,
  output logic [15:0]      underrun_cnt
);

  sink_state_t state;
  sample_t     pend_l;
  sample_t     pend_r;
  logic        tick;
  logic        fetching;
  logic        xfer;

  audio_rate_nco #(.ACC_W(ACC_W)) u_nco (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .rate_inc (rate_inc),
    .tick     (tick)
  );

  assign fetching  = (state == FETCH_L) || (state == FETCH_R);
  assign in.strobe = fetching && in.write && !reset;
  assign xfer      = in.write && in.strobe;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      // NOTE: the pending words are reset along with everything else so a frame
      // discarded by reset can never reach the outputs later.
      pend_l       <= '0;
      pend_r       <= '0;
      left_out     <= '0;
      right_out    <= '0;
      sample_tick  <= 1'b0;
      underrun     <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      sample_tick <= 1'b0;
      underrun    <= tick && fetching;
      if (tick && fetching && (underrun_cnt != UNDERRUN_MAX))
        underrun_cnt <= underrun_cnt + 16'd1;

      // A missed tick leaves the state alone, so L/R alignment survives starvation.
      case (state)
        IDLE: begin
          if (tick) state <= FETCH_L;
        end
        FETCH_L: begin
          if (xfer) begin
            pend_l <= in.sample;
            if (stereo) begin
              state <= FETCH_R;
            end else begin
              pend_r <= in.sample;
              state  <= PRESENT;
            end
          end
        end
        FETCH_R: begin
          if (xfer) begin
            pend_r <= in.sample;
            state  <= PRESENT;
          end
        end
        PRESENT: begin
          left_out    <= pend_l;
          right_out   <= pend_r;
          sample_tick <= 1'b1;
          state       <= tick ? FETCH_L : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_rate_sink.sv
// Self-checking bench for audio_rate_sink: directed scenarios plus randomized traffic,
// every cycle compared against a frame-level reference model of the sink.
module tb_audio_rate_sink;
  import audio_pkg::*;

  localparam int ACC_W = NCO_ACC_W;

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic             stereo;
  logic [ACC_W-1:0] rate_inc;
  sample_t          left_out;
  sample_t          right_out;
  logic             sample_tick;
  logic             underrun;
  logic [15:0]      underrun_cnt;

  audiostream_if in_if ();

  audio_rate_sink #(.ACC_W(ACC_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .in           (in_if),
    .enable       (enable),
    .stereo       (stereo),
    .rate_inc     (rate_inc),
    .left_out     (left_out),
    .right_out    (right_out),
    .sample_tick  (sample_tick),
    .underrun     (underrun),
    .underrun_cnt (underrun_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Source side
  sample_t src_q[$];
  bit      want_write;

  // Reference model: NCO as plain modular arithmetic, frame assembled as a word list.
  int unsigned m_acc;
  bit          m_tick;
  int          m_need;        // >0 while a frame is still being collected
  sample_t     m_words[$];
  bit          m_present_due;
  sample_t     m_left, m_right;
  bit          m_stick, m_under;
  int          m_cnt;

  // Observations
  int      cyc = 0;
  int      n_xfer = 0;
  int      n_under_seen = 0;
  sample_t seen_l[$], seen_r[$];
  int      st_cyc[$], tk_cyc[$];

  task automatic step();
    bit          xfer_exp, dut_xfer, tick_now, was_fetching, present_now;
    int unsigned sum;
    sample_t     s;
    in_if.write  = want_write && (src_q.size() > 0);
    in_if.sample = (src_q.size() > 0) ? src_q[0] : sample_t'(0);
    @(negedge clk);
    check("strobe", 32'(in_if.strobe), 32'((m_need > 0) && in_if.write && !reset));
    check("sample_tick", 32'(sample_tick), 32'(m_stick));
    check("underrun", 32'(underrun), 32'(m_under));
    check("underrun_cnt", 32'(underrun_cnt), 32'(m_cnt));
    check("left_out", 32'(left_out), 32'(m_left));
    check("right_out", 32'(right_out), 32'(m_right));
    if (m_tick) tk_cyc.push_back(cyc);
    if (sample_tick) begin
      seen_l.push_back(left_out);
      seen_r.push_back(right_out);
      st_cyc.push_back(cyc);
    end
    if (underrun) n_under_seen++;
    dut_xfer = in_if.write && in_if.strobe;
    xfer_exp = (m_need > 0) && in_if.write;
    s        = in_if.sample;

    if (reset) begin
      m_acc = 0; m_tick = 0; m_need = 0; m_words.delete(); m_present_due = 0;
      m_left = 0; m_right = 0; m_stick = 0; m_under = 0; m_cnt = 0;
    end else begin
      tick_now     = m_tick;
      was_fetching = (m_need > 0);
      present_now  = m_present_due;
      m_stick = present_now;
      if (present_now) begin
        m_left  = m_words[0];
        m_right = m_words[1];
        m_words.delete();
      end
      m_under = tick_now && was_fetching;
      if (m_under && m_cnt < 65535) m_cnt++;
      m_present_due = 0;
      if (xfer_exp) begin
        m_words.push_back(s);
        if (m_words.size() == 1 && !stereo) m_words.push_back(s);
        m_need = 2 - m_words.size();
        if (m_need == 0) m_present_due = 1;
      end else if (!was_fetching && tick_now) begin
        m_need = 2;
      end
      if (enable) begin
        sum    = m_acc + 32'(rate_inc);
        m_tick = sum[ACC_W];
        m_acc  = sum & ((32'd1 << ACC_W) - 1);
      end else begin
        m_acc  = 0;
        m_tick = 0;
      end
    end

    @(posedge clk);
    if (dut_xfer) begin
      void'(src_q.pop_front());
      n_xfer++;
    end
    #1;
    cyc++;
  endtask

  task automatic clear_obs();
    seen_l.delete(); seen_r.delete(); st_cyc.delete(); tk_cyc.delete();
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) step();
    reset = 1'b0;
    clear_obs();
  endtask

  task automatic check_frame(input string tag, input int idx, input sample_t l, input sample_t r);
    if (seen_l.size() > idx) begin
      check({tag, "_L"}, 32'(seen_l[idx]), 32'(l));
      check({tag, "_R"}, 32'(seen_r[idx]), 32'(r));
    end else begin
      check({tag, "_present"}, 32'(seen_l.size()), 32'(idx + 1));
    end
  endtask

  initial begin
    int x0, u0, k;
    reset = 1'b1; enable = 1'b0; stereo = 1'b1; rate_inc = '0; want_write = 1'b0;
    in_if.write = 1'b0; in_if.sample = '0;
    do_reset(3);
    check("rst_left", 32'(left_out), 32'd0);
    check("rst_right", 32'(right_out), 32'd0);
    check("rst_cnt", 32'(underrun_cnt), 32'd0);
    check("rst_tick", 32'(sample_tick), 32'd0);

    // Stereo, 8 clk per tick, source always valid
    stereo = 1'b1; rate_inc = 24'(1 << 21); enable = 1'b1; want_write = 1'b1;
    src_q = '{16'sh1111, 16'sh2222, 16'sh3333, 16'sh4444};
    repeat (40) step();
    check_frame("t2_f1", 0, 16'sh1111, 16'sh2222);
    check_frame("t2_f2", 1, 16'sh3333, 16'sh4444);
    if (st_cyc.size() >= 2 && tk_cyc.size() >= 1) begin
      check("t2_period", 32'(st_cyc[1] - st_cyc[0]), 32'd8);
      check("t2_latency", 32'(st_cyc[0] - tk_cyc[0]), 32'd4);
    end else begin
      check("t2_ticks_seen", 32'(st_cyc.size()), 32'd2);
    end

    // Reset mid-run while a fetch is pending and the source is offering data
    src_q = '{16'sh5555, 16'sh6666};
    do_reset(3);
    check("t1_left", 32'(left_out), 32'd0);
    check("t1_right", 32'(right_out), 32'd0);
    check("t1_cnt", 32'(underrun_cnt), 32'd0);
    check("t1_src_kept", 32'(src_q.size()), 32'd2);
    repeat (14) step();
    check_frame("t1_f1", 0, 16'sh5555, 16'sh6666);

    // Mono: each word duplicated, one transfer per tick
    do_reset(2);
    stereo = 1'b0;
    src_q = '{16'sh8000, 16'sh7FFF};
    x0 = n_xfer;
    repeat (22) step();
    check_frame("t3_f1", 0, 16'sh8000, 16'sh8000);
    check_frame("t3_f2", 1, 16'sh7FFF, 16'sh7FFF);
    check("t3_xfers", 32'(n_xfer - x0), 32'd2);

    // Stereo starvation after the L word: two missed ticks, alignment kept
    do_reset(2);
    stereo = 1'b1;
    src_q = '{16'sh00A1, 16'sh00B2, 16'sh00C3, 16'sh00D4};
    x0 = n_xfer; u0 = n_under_seen; k = 0;
    while (n_xfer == x0 && k < 50) begin step(); k++; end
    check("t4_l_xfer", 32'(n_xfer - x0), 32'd1);
    want_write = 1'b0;
    repeat (20) step();
    check("t4_held_L", 32'(left_out), 32'd0);
    want_write = 1'b1;
    repeat (4) step();
    check("t4_cnt", 32'(underrun_cnt), 32'd2);
    check("t4_pulses", 32'(n_under_seen - u0), 32'd2);
    repeat (20) step();
    check_frame("t4_f1", 0, 16'sh00A1, 16'sh00B2);
    check_frame("t4_f2", 1, 16'sh00C3, 16'sh00D4);

    // Source valid every 3rd cycle, 16 clk per tick
    do_reset(2);
    rate_inc = 24'(1 << 20);
    src_q = '{16'sh0101, 16'sh0202, 16'sh0303, 16'sh0404, 16'sh0505, 16'sh0606};
    u0 = n_under_seen;
    for (int i = 0; i < 60; i++) begin
      want_write = (cyc % 3 == 0);
      step();
    end
    want_write = 1'b1;
    check("t5_no_underrun", 32'(n_under_seen - u0), 32'd0);
    check_frame("t5_f1", 0, 16'sh0101, 16'sh0202);
    check_frame("t5_f2", 1, 16'sh0303, 16'sh0404);
    check_frame("t5_f3", 2, 16'sh0505, 16'sh0606);

    // Randomized traffic
    do_reset(2);
    src_q.delete();
    for (int i = 0; i < 1500; i++) begin
      if (i % 100 == 0) rate_inc = 24'($urandom_range(1 << 20, 1 << 22));
      if ($urandom_range(0, 15) == 0) stereo = ~stereo;
      if ($urandom_range(0, 199) == 0) enable = ~enable;
      reset      = ($urandom_range(0, 399) == 0);
      want_write = ($urandom_range(0, 3) != 0);
      while (src_q.size() < 4) src_q.push_back(sample_t'($urandom));
      step();
    end
    reset = 1'b0; enable = 1'b1; want_write = 1'b1;

    // Long starvation at maximum tick rate, then enable drops mid-frame
    src_q.delete();
    do_reset(2);
    stereo = 1'b1; rate_inc = 24'hFFFFFF; want_write = 1'b0;
    k = 0;
    while (underrun_cnt != 16'hFFFF && k < 70000) begin step(); k++; end
    repeat (3) step();
    check("t6_saturated", 32'(underrun_cnt), 32'h0000FFFF);
    check("t6_pulse_at_sat", 32'(underrun), 32'd1);
    enable = 1'b0;
    src_q = '{16'sh0A0A, 16'sh0B0B};
    want_write = 1'b1;
    clear_obs();
    repeat (40) step();
    check("t6_one_frame", 32'(seen_l.size()), 32'd1);
    check_frame("t6_f1", 0, 16'sh0A0A, 16'sh0B0B);
    check("t6_cnt_hold", 32'(underrun_cnt), 32'h0000FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
